key_text_buffer: RTL and testbench



---
 rtl/key_text_buffer.sv | 257 +++++++++++++++++++++++++
 tb/tb_key_text_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_text_buffer.sv
// key_text_buffer
// Turns the level-coded ASCII key from the keyboard stage into discrete key
// events (press plus auto-repeat) and edits a ROWS x COLS character screen
// kept in internal RAM. Scrolling is done by moving the physical row that is
// shown as logical row 0 instead of copying lines.
//
// Ports:
//   clk        system clock
//   clr        asynchronous active-high reset, restarts the screen clear
//   ascii_key  ASCII of the held key, 0x00 when no key is held
//   rd_row     logical row to read, 0 is the top of the screen
//   rd_col     column to read
//   rd_data    registered character at (rd_row, rd_col)
//   cursor_row logical cursor row
//   cursor_col cursor column
//   top_row    physical RAM row currently shown as logical row 0
//   busy       high while the screen is being cleared (whole or one line)
//   lost       sticky flag, set when a key event had to be dropped
//   key_count  number of key events applied, wraps at 16 bits
module key_text_buffer #(
  parameter int COLS          = 70,
  parameter int ROWS          = 30,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [7:0]                ascii_key,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [7:0]                rd_data,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   top_row,
  output logic                      busy,
  output logic                      lost,
  output logic [15:0]               key_count
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RCW   = $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [7:0]      prev_q;
  logic [RCW-1:0]  repCnt_q, repCnt_d;
  logic            pendValid_q, pendValid_d;
  logic [7:0]      pendCode_q, pendCode_d;
  logic [RW-1:0]   cursorRow_q, cursorRow_d;
  logic [CW-1:0]   cursorCol_q, cursorCol_d;
  logic [RW-1:0]   topRow_q, topRow_d;
  logic [15:0]     keyCount_q, keyCount_d;
  logic            lost_q, lost_d;
  logic [AW-1:0]   initCnt_q, initCnt_d;
  logic [CW-1:0]   clrCol_q, clrCol_d;
  logic [7:0]      rdData_q;

  logic            keyChanged, pressEvt, repeatEvt, evtValid;
  logic            applyEvt, newLine;
  logic [7:0]      applyCode;
  logic            memWe;
  logic [AW-1:0]   memAddr;
  logic [7:0]      memData;
  logic [AW-1:0]   rdAddr;
  logic            rdInRange;

  logic [7:0]      mem [CELLS];

  // Logical row plus the scroll offset wraps around the RAM rows; the cell
  // address is then row-major within the physical row.
  function automatic logic [AW-1:0] cellAddr(input logic [RW-1:0] logRow,
                                             input logic [RW-1:0] top,
                                             input logic [CW-1:0] col);
    int phys;
    int addr;
    phys = int'(logRow) + int'(top);
    if (phys >= ROWS) phys = phys - ROWS;
    addr = phys * COLS + int'(col);
    return addr[AW-1:0];
  endfunction

  // Key events: a new nonzero code is a press. While the same code stays held
  // the counter runs; it fires the first repeat REPEAT_DELAY cycles after the
  // press and is then reloaded so later repeats come every REPEAT_PERIOD.
  always_comb begin
    keyChanged = (ascii_key != prev_q);
    pressEvt   = keyChanged && (ascii_key != 8'h00);
    repeatEvt  = !keyChanged && (ascii_key != 8'h00) &&
                 (int'(repCnt_q) == REPEAT_DELAY - 1);
    evtValid   = pressEvt || repeatEvt;
    repCnt_d   = repCnt_q + RCW'(1);
    if (keyChanged || (ascii_key == 8'h00)) begin
      repCnt_d = '0;
    end else if (repeatEvt) begin
      repCnt_d = RCW'(REPEAT_DELAY - REPEAT_PERIOD);
    end
  end

  // Main controller. INIT blanks the whole RAM, IDLE applies one event per
  // cycle (a held pending event always goes first), CLEAR blanks the line the
  // cursor just moved onto. Events seen outside IDLE park in the single
  // pending slot; anything beyond that is dropped and flagged.
  always_comb begin
    state_d     = state_q;
    pendValid_d = pendValid_q;
    pendCode_d  = pendCode_q;
    cursorRow_d = cursorRow_q;
    cursorCol_d = cursorCol_q;
    topRow_d    = topRow_q;
    keyCount_d  = keyCount_q;
    lost_d      = lost_q;
    initCnt_d   = initCnt_q;
    clrCol_d    = clrCol_q;
    memWe       = 1'b0;
    memAddr     = '0;
    memData     = 8'h20;
    applyEvt    = 1'b0;
    applyCode   = 8'h00;
    newLine     = 1'b0;
    case (state_q)
      INIT: begin
        memWe     = 1'b1;
        memAddr   = initCnt_q;
        initCnt_d = initCnt_q + AW'(1);
        if (int'(initCnt_q) == CELLS - 1) begin
          initCnt_d = '0;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        if (pendValid_q) begin
          applyEvt    = 1'b1;
          applyCode   = pendCode_q;
          pendValid_d = 1'b0;
          if (evtValid) lost_d = 1'b1;
        end else if (evtValid) begin
          applyEvt  = 1'b1;
          applyCode = ascii_key;
        end
        if (applyEvt) begin
          keyCount_d = keyCount_q + 16'd1;
          if ((applyCode >= 8'h20) && (applyCode <= 8'h7E)) begin
            memWe   = 1'b1;
            memAddr = cellAddr(cursorRow_q, topRow_q, cursorCol_q);
            memData = applyCode;
            if (int'(cursorCol_q) == COLS - 1) begin
              cursorCol_d = '0;
              newLine     = 1'b1;
            end else begin
              cursorCol_d = cursorCol_q + CW'(1);
            end
          end else if ((applyCode == 8'h0D) || (applyCode == 8'h0A)) begin
            cursorCol_d = '0;
            newLine     = 1'b1;
          end else if (applyCode == 8'h08) begin
            if (cursorCol_q != '0) begin
              cursorCol_d = cursorCol_q - CW'(1);
              memWe       = 1'b1;
              memAddr     = cellAddr(cursorRow_q, topRow_q, cursorCol_d);
            end else if (cursorRow_q != '0) begin
              cursorRow_d = cursorRow_q - RW'(1);
              cursorCol_d = CW'(COLS - 1);
              memWe       = 1'b1;
              memAddr     = cellAddr(cursorRow_d, topRow_q, cursorCol_d);
            end
          end
          if (newLine) begin
            if (int'(cursorRow_q) == ROWS - 1) begin
              topRow_d = (int'(topRow_q) == ROWS - 1) ? '0 : topRow_q + RW'(1);
            end else begin
              cursorRow_d = cursorRow_q + RW'(1);
            end
            clrCol_d = '0;
            state_d  = CLEAR;
          end
        end
      end
      CLEAR: begin
        memWe    = 1'b1;
        memAddr  = cellAddr(cursorRow_q, topRow_q, clrCol_q);
        clrCol_d = clrCol_q + CW'(1);
        if (int'(clrCol_q) == COLS - 1) begin
          clrCol_d = '0;
          state_d  = IDLE;
        end
        if (evtValid) begin
          if (pendValid_q) begin
            lost_d = 1'b1;
          end else begin
            pendValid_d = 1'b1;
            pendCode_d  = ascii_key;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Read address uses the same scroll mapping as the writers; rows or
  // columns outside the screen read back as 0x00.
  always_comb begin
    rdAddr    = cellAddr(rd_row, topRow_q, rd_col);
    rdInRange = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  end

  // All control state. Reset drops straight back into INIT from anywhere.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= INIT;
      prev_q      <= 8'h00;
      repCnt_q    <= '0;
      pendValid_q <= 1'b0;
      pendCode_q  <= 8'h00;
      cursorRow_q <= '0;
      cursorCol_q <= '0;
      topRow_q    <= '0;
      keyCount_q  <= 16'd0;
      lost_q      <= 1'b0;
      initCnt_q   <= '0;
      clrCol_q    <= '0;
      rdData_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      prev_q      <= ascii_key;
      repCnt_q    <= repCnt_d;
      pendValid_q <= pendValid_d;
      pendCode_q  <= pendCode_d;
      cursorRow_q <= cursorRow_d;
      cursorCol_q <= cursorCol_d;
      topRow_q    <= topRow_d;
      keyCount_q  <= keyCount_d;
      lost_q      <= lost_d;
      initCnt_q   <= initCnt_d;
      clrCol_q    <= clrCol_d;
      rdData_q    <= rdInRange ? mem[rdAddr] : 8'h00;
    end
  end

  // Screen RAM, one write port. The read above samples the array before this
  // edge's write lands, so a same-cycle read returns the old character.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  assign rd_data    = rdData_q;
  assign cursor_row = cursorRow_q;
  assign cursor_col = cursorCol_q;
  assign top_row    = topRow_q;
  assign busy       = (state_q != IDLE);
  assign lost       = lost_q;
  assign key_count  = keyCount_q;

endmodule

// File: tb/tb_key_text_buffer.sv
// Bench for key_text_buffer with a small screen and short repeat times.
// The reference model keeps the screen as logical lines that are shifted on
// scroll and counts how long a key has been held; each cycle's expected
// outputs go into a queue that a monitor drains and compares.
module tb_key_text_buffer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int RD   = 20;
  localparam int RP   = 5;

  logic        clk;
  logic        clr;
  logic [7:0]  ascii_key;
  logic [1:0]  rd_row;
  logic [1:0]  rd_col;
  logic [7:0]  rd_data;
  logic [1:0]  cursor_row;
  logic [1:0]  cursor_col;
  logic [1:0]  top_row;
  logic        busy;
  logic        lost;
  logic [15:0] key_count;

  key_text_buffer #(
    .COLS(COLS), .ROWS(ROWS), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .clr(clr), .ascii_key(ascii_key), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .top_row(top_row), .busy(busy), .lost(lost),
    .key_count(key_count)
  );

  typedef struct {
    bit hasRead;
    int rd;
    int row;
    int col;
    int top;
    int cnt;
    int lost;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   probeReq = 0;
  bit   probeSeen = 0;

  // Reference model state
  logic [7:0] lines [ROWS][COLS];
  int         mRow, mCol, mTop, mCount, mLost, mBusy, mHeld;
  bit         mInit, mPendV;
  logic [7:0] mPend, mPrev;

  // 100 MHz-style clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never settles
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) lines[r][c] = 8'h20;
    mRow = 0; mCol = 0; mTop = 0; mCount = 0; mLost = 0; mHeld = 0;
    mBusy = ROWS * COLS; mInit = 1; mPendV = 0; mPend = 8'h00; mPrev = 8'h00;
  endtask

  task automatic modelApply(input logic [7:0] c);
    bit nl;
    nl = 0;
    mCount = (mCount + 1) & 16'hFFFF;
    if (c >= 8'h20 && c <= 8'h7E) begin
      lines[mRow][mCol] = c;
      mCol++;
      if (mCol == COLS) begin mCol = 0; nl = 1; end
    end else if (c == 8'h0D || c == 8'h0A) begin
      mCol = 0; nl = 1;
    end else if (c == 8'h08) begin
      if (mCol > 0) begin
        mCol--; lines[mRow][mCol] = 8'h20;
      end else if (mRow > 0) begin
        mRow--; mCol = COLS - 1; lines[mRow][mCol] = 8'h20;
      end
    end
    if (nl) begin
      if (mRow < ROWS - 1) begin
        mRow++;
      end else begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int k = 0; k < COLS; k++) lines[r][k] = lines[r + 1][k];
        mTop = (mTop + 1) % ROWS;
      end
      for (int k = 0; k < COLS; k++) lines[mRow][k] = 8'h20;
      mBusy = COLS;
    end
  endtask

  // One clock of the model: key k is what the design sees at the next edge
  task automatic modelStep(input logic [7:0] k);
    bit ev;
    ev = 0;
    if (k != 8'h00 && k != mPrev) begin
      ev = 1; mHeld = 0;
    end else if (k != 8'h00) begin
      mHeld++;
      ev = (mHeld >= RD) && (((mHeld - RD) % RP) == 0);
    end else begin
      mHeld = 0;
    end
    mPrev = k;
    if (mInit) begin
      mBusy--;
      if (mBusy == 0) mInit = 0;
    end else if (mBusy > 0) begin
      if (ev) begin
        if (mPendV) mLost = 1;
        else begin mPendV = 1; mPend = k; end
      end
      mBusy--;
    end else if (mPendV) begin
      mPendV = 0;
      if (ev) mLost = 1;
      modelApply(mPend);
    end else if (ev) begin
      modelApply(k);
    end
  endtask

  // Drives one cycle of inputs (called at posedge+1) and queues the expected
  // outputs that become visible after the coming edge.
  task automatic applyStimulus(input logic [7:0] k, input bit doRead,
                               input int rr, input int rc);
    exp_t e;
    ascii_key = k;
    rd_row    = 2'(rr);
    rd_col    = 2'(rc);
    e.hasRead = doRead && (mBusy == 0);
    e.rd      = e.hasRead ? int'(lines[rr][rc]) : 0;
    modelStep(k);
    e.row  = mRow;
    e.col  = mCol;
    e.top  = mTop;
    e.cnt  = mCount;
    e.lost = mLost;
    e.busy = (mBusy > 0) ? 1 : 0;
    sb.push_back(e);
    probeReq = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a queued expectation is due whenever a probed cycle has passed
  always @(posedge clk) probeSeen <= probeReq;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (probeSeen) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("mon_busy", int'(busy), e.busy);
          checkOutput("mon_row", int'(cursor_row), e.row);
          checkOutput("mon_col", int'(cursor_col), e.col);
          checkOutput("mon_top", int'(top_row), e.top);
          checkOutput("mon_count", int'(key_count), e.cnt);
          checkOutput("mon_lost", int'(lost), e.lost);
          if (e.hasRead) checkOutput("mon_rd_data", int'(rd_data), e.rd);
        end
      end
    end
  end

  task automatic doReset();
    probeReq  = 1'b0;
    ascii_key = 8'h00;
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_row", int'(cursor_row), 0);
    checkOutput("rst_col", int'(cursor_col), 0);
    checkOutput("rst_top", int'(top_row), 0);
    checkOutput("rst_count", int'(key_count), 0);
    checkOutput("rst_lost", int'(lost), 0);
    checkOutput("rst_rd_data", int'(rd_data), 0);
    sb.delete();
    modelReset();
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 0, 0, 0);
  endtask

  task automatic settle();
    int guard;
    guard = 0;
    applyStimulus(8'h00, 0, 0, 0);
    while ((mBusy > 0 || mPendV) && guard < 100) begin
      applyStimulus(8'h00, 0, 0, 0);
      guard++;
    end
  endtask

  task automatic typeKey(input logic [7:0] k);
    applyStimulus(k, 0, 0, 0);
    settle();
  endtask

  task automatic readAll();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) applyStimulus(8'h00, 1, r, c);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] k;
    int n;
    pool = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h0D, 8'h08, 8'h07, 8'h0A};
    clr = 1'b1; ascii_key = 8'h00; rd_row = 2'd0; rd_col = 2'd0;
    modelReset();

    // Power-up clear timing and blank screen
    doReset();
    idle(11);
    checkOutput("t1_busy_11", int'(busy), 1);
    idle(1);
    checkOutput("t1_busy_12", int'(busy), 0);
    readAll();

    // Two separate presses
    for (int i = 0; i < 3; i++) applyStimulus(8'h41, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h42, 0, 0, 0);
    settle();
    checkOutput("t2_count", int'(key_count), 2);
    checkOutput("t2_col", int'(cursor_col), 2);
    readAll();

    // Auto-repeat fills a line and wraps
    doReset();
    idle(12);
    for (int i = 0; i < 32; i++) applyStimulus(8'h43, 0, 0, 0);
    settle();
    checkOutput("t3_row", int'(cursor_row), 1);
    checkOutput("t3_col", int'(cursor_col), 0);
    checkOutput("t3_count", int'(key_count), 4);
    readAll();

    // Scroll after twelve characters
    doReset();
    idle(12);
    for (int i = 0; i < 12; i++) typeKey(8'h41 + 8'(i));
    checkOutput("t4_top", int'(top_row), 1);
    checkOutput("t4_row", int'(cursor_row), 2);
    readAll();

    // Backspace across a line boundary and at the home position
    doReset();
    idle(12);
    for (int i = 0; i < 4; i++) typeKey(8'h61 + 8'(i));
    typeKey(8'h08);
    checkOutput("t5_row", int'(cursor_row), 0);
    checkOutput("t5_col", int'(cursor_col), 3);
    for (int i = 0; i < 4; i++) typeKey(8'h08);
    checkOutput("t5_home_col", int'(cursor_col), 0);
    checkOutput("t5_count", int'(key_count), 9);
    readAll();

    // Keys during a line clear: one parks, one is lost; then reset mid-clear
    doReset();
    idle(12);
    for (int i = 0; i < 3; i++) typeKey(8'h61 + 8'(i));
    applyStimulus(8'h58, 0, 0, 0);
    applyStimulus(8'h59, 0, 0, 0);
    applyStimulus(8'h5A, 0, 0, 0);
    settle();
    checkOutput("t6_lost", int'(lost), 1);
    checkOutput("t6_count", int'(key_count), 5);
    readAll();
    applyStimulus(8'h0D, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    doReset();

    // Randomized key traffic with reads
    idle(12);
    for (int s = 0; s < 60; s++) begin
      k = pool[$urandom_range(0, 7)];
      n = $urandom_range(1, 28);
      for (int i = 0; i < n; i++)
        applyStimulus(k, bit'($urandom_range(0, 1)),
                      $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
    end
    settle();
    readAll();

    #10;
    checkOutput("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
